// File: rtl/ground_scroller.sv
// ground_scroller
//   Draws the scrolling grass band along the bottom of the playfield.
//   Screen coordinates are turned into tile-local coordinates (with a
//   per-frame horizontal scroll) for the grass sprite ROM. The returned tile
//   colour is then composited over the background pixel using the tile mask.
//   Fixed latency of 2 cycles, one pixel per clock.
//
// Ports
//   i_clk, i_rst             pixel clock, asynchronous active-high reset
//   i_px, i_py, i_pix_valid  current pixel coordinate and active flag
//   i_bg_r/g/b               background colour for this pixel
//   i_frame_tick             one pulse per frame (vertical blanking)
//   i_run                    level, scrolling enabled
//   i_restart                pulse, return scroll to 0 on the next frame tick
//   o_tile_x, o_tile_y       coordinate to the sprite ROM
//   i_tile_r/g/b, i_tile_mask  sprite ROM colour and opacity
//   o_out_r/g/b, o_out_valid   composited pixel
//   o_scroll_pos             current scroll offset
module ground_scroller #(
  parameter int GROUND_Y = 400,
  parameter int GROUND_H = 80,
  parameter int TILE     = 16,
  parameter int SPEED    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [10:0] i_px,
  input  logic [10:0] i_py,
  input  logic        i_pix_valid,
  input  logic [7:0]  i_bg_r,
  input  logic [7:0]  i_bg_g,
  input  logic [7:0]  i_bg_b,
  input  logic        i_frame_tick,
  input  logic        i_run,
  input  logic        i_restart,
  output logic [10:0] o_tile_x,
  output logic [10:0] o_tile_y,
  input  logic [7:0]  i_tile_r,
  input  logic [7:0]  i_tile_g,
  input  logic [7:0]  i_tile_b,
  input  logic        i_tile_mask,
  output logic [7:0]  o_out_r,
  output logic [7:0]  o_out_g,
  output logic [7:0]  o_out_b,
  output logic        o_out_valid,
  output logic [3:0]  o_scroll_pos
);

  localparam int SW = $clog2(TILE);

  localparam logic [0:0] S_STOPPED = 1'b0;
  localparam logic [0:0] S_RUNNING = 1'b1;

  logic [0:0]    r_state;
  logic [SW-1:0] r_scroll;
  logic          r_pend_restart;

  // Scroll control: everything changes on the frame tick only, so a frame
  // is always drawn with a single scroll value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_STOPPED;
      r_scroll       <= '0;
      r_pend_restart <= 1'b0;
    end else if (i_frame_tick) begin
      r_state <= i_run ? S_RUNNING : S_STOPPED;
      if (r_pend_restart || i_restart) begin
        r_scroll       <= '0;
        r_pend_restart <= 1'b0;
      end else if (r_state == S_RUNNING) begin
        // Truncation to SW bits gives the modulo-TILE wrap.
        r_scroll <= r_scroll + SW'(SPEED);
      end
    end else if (i_restart) begin
      r_pend_restart <= 1'b1;
    end
  end

  assign o_scroll_pos = 4'(r_scroll);

  // Stage 1: tile coordinates and delayed pixel data.
  logic        w_in_band;
  logic [10:0] w_sum_x;
  logic [10:0] w_dy;

  assign w_in_band = i_pix_valid && (i_py >= 11'(GROUND_Y)) &&
                     (i_py < 11'(GROUND_Y + GROUND_H));
  assign w_sum_x   = i_px + {{(11 - SW){1'b0}}, r_scroll};
  assign w_dy      = i_py - 11'(GROUND_Y);

  logic [10:0] r_tile_x;
  logic [10:0] r_tile_y;
  logic [23:0] r_bg;
  logic        r_valid1;
  logic        r_in_band1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tile_x   <= 11'(TILE);
      r_tile_y   <= 11'(TILE);
      r_bg       <= '0;
      r_valid1   <= 1'b0;
      r_in_band1 <= 1'b0;
    end else begin
      // Out of band the coordinate is parked at TILE, outside the ROM,
      // which makes the ROM report a transparent texel.
      if (w_in_band) begin
        r_tile_x <= {{(11 - SW){1'b0}}, w_sum_x[SW-1:0]};
        r_tile_y <= {{(11 - SW){1'b0}}, w_dy[SW-1:0]};
      end else begin
        r_tile_x <= 11'(TILE);
        r_tile_y <= 11'(TILE);
      end
      r_bg       <= {i_bg_r, i_bg_g, i_bg_b};
      r_valid1   <= i_pix_valid;
      r_in_band1 <= w_in_band;
    end
  end

  assign o_tile_x = r_tile_x;
  assign o_tile_y = r_tile_y;

  // Stage 2: composite, one identical mux per colour channel.
  logic [23:0] w_tile_rgb;
  logic [23:0] r_out;
  logic        r_valid2;
  logic        w_use_tile;

  assign w_tile_rgb = {i_tile_r, i_tile_g, i_tile_b};
  assign w_use_tile = r_in_band1 && i_tile_mask;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_out[gi*8 +: 8] <= '0;
        end else if (!r_valid1) begin
          r_out[gi*8 +: 8] <= '0;
        end else if (w_use_tile) begin
          r_out[gi*8 +: 8] <= w_tile_rgb[gi*8 +: 8];
        end else begin
          r_out[gi*8 +: 8] <= r_bg[gi*8 +: 8];
        end
      end
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid2 <= 1'b0;
    end else begin
      r_valid2 <= r_valid1;
    end
  end

  assign o_out_r     = r_out[23:16];
  assign o_out_g     = r_out[15:8];
  assign o_out_b     = r_out[7:0];
  assign o_out_valid = r_valid2;

endmodule

// File: tb/tb_ground_scroller.sv
module tb_ground_scroller;
  logic        clk;
  logic        rst;
  logic [10:0] px, py;
  logic        pix_valid;
  logic [7:0]  bg_r, bg_g, bg_b;
  logic        frame_tick, run, restart;
  logic [10:0] tile_x, tile_y;
  logic [7:0]  tile_r, tile_g, tile_b;
  logic        tile_mask;
  logic [7:0]  out_r, out_g, out_b;
  logic        out_valid;
  logic [3:0]  scroll_pos;

  int total = 0;
  int bad   = 0;

  ground_scroller dut (
    .i_clk(clk), .i_rst(rst),
    .i_px(px), .i_py(py), .i_pix_valid(pix_valid),
    .i_bg_r(bg_r), .i_bg_g(bg_g), .i_bg_b(bg_b),
    .i_frame_tick(frame_tick), .i_run(run), .i_restart(restart),
    .o_tile_x(tile_x), .o_tile_y(tile_y),
    .i_tile_r(tile_r), .i_tile_g(tile_g), .i_tile_b(tile_b),
    .i_tile_mask(tile_mask),
    .o_out_r(out_r), .o_out_g(out_g), .o_out_b(out_b),
    .o_out_valid(out_valid), .o_scroll_pos(scroll_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one frame tick pulse, driven on the falling edge
  task automatic do_tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  // present a pixel for one cycle; returns after the stage-1 edge (+1)
  task automatic drive_pix(input logic [10:0] x, input logic [10:0] y,
                           input logic [23:0] bg);
    @(negedge clk);
    px = x; py = y; pix_valid = 1'b1;
    {bg_r, bg_g, bg_b} = bg;
    @(posedge clk); #1;
    @(negedge clk) pix_valid = 1'b0;
    {bg_r, bg_g, bg_b} = 24'h0;
  endtask

  task automatic test_reset();
    total++; if (tile_x !== 11'd16) begin bad++; $display("FAIL reset_tile_x got=%0d want=16", tile_x); end
    total++; if (tile_y !== 11'd16) begin bad++; $display("FAIL reset_tile_y got=%0d want=16", tile_y); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if ({out_r, out_g, out_b} !== 24'h0) begin bad++; $display("FAIL reset_out got=%h want=000000", {out_r, out_g, out_b}); end
    total++; if (scroll_pos !== 4'd0) begin bad++; $display("FAIL reset_scroll got=%0d want=0", scroll_pos); end
    $display("reset: tile=(%0d,%0d) out_valid=%b scroll=%0d", tile_x, tile_y, out_valid, scroll_pos);
  endtask

  task automatic test_stopped();
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_tick();
      total++; if (scroll_pos !== 4'd0) begin bad++; $display("FAIL stopped_scroll tick=%0d got=%0d want=0", i, scroll_pos); end
      $display("stopped tick %0d: scroll=%0d", i, scroll_pos);
    end
    tile_r = 8'h50; tile_g = 8'h60; tile_b = 8'h70; tile_mask = 1'b1;
    drive_pix(11'd5, 11'd400, 24'h010203);
    // now after stage-2 edge? no: drive_pix returns at the following negedge
    @(posedge clk); #1;
    total++; if (out_r !== 8'h50) begin bad++; $display("FAIL opaque_out_r got=%h want=50", out_r); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL opaque_out_valid got=%b want=1", out_valid); end
    $display("pixel (5,400): out=%h%h%h valid=%b", out_r, out_g, out_b, out_valid);
  endtask

  task automatic test_scroll();
    logic [3:0] exp_s;
    run = 1'b1;
    do_tick(); // leaves STOPPED; no advance on this tick
    total++; if (scroll_pos !== 4'd0) begin bad++; $display("FAIL scroll_enter got=%0d want=0", scroll_pos); end
    exp_s = 4'd0;
    for (int i = 1; i <= 8; i++) begin
      do_tick();
      exp_s = exp_s + 4'd2;
      total++; if (scroll_pos !== exp_s) begin bad++; $display("FAIL scroll_step tick=%0d got=%0d want=%0d", i, scroll_pos, exp_s); end
      $display("run tick %0d: scroll=%0d", i, scroll_pos);
      if (i == 7) begin
        @(negedge clk);
        px = 11'd3; py = 11'd410; pix_valid = 1'b1;
        @(posedge clk); #1;
        total++; if (tile_x !== 11'd1) begin bad++; $display("FAIL scroll14_tile_x got=%0d want=1", tile_x); end
        total++; if (tile_y !== 11'd10) begin bad++; $display("FAIL scroll14_tile_y got=%0d want=10", tile_y); end
        $display("px=3 py=410 scroll=14: tile=(%0d,%0d)", tile_x, tile_y);
        @(negedge clk) pix_valid = 1'b0;
      end
    end
    run = 1'b0;
    do_tick(); // back to STOPPED (scroll still advances this tick: 0->2)
    total++; if (scroll_pos !== 4'd2) begin bad++; $display("FAIL scroll_stop_tick got=%0d want=2", scroll_pos); end
    do_tick();
    total++; if (scroll_pos !== 4'd2) begin bad++; $display("FAIL scroll_stopped_hold got=%0d want=2", scroll_pos); end
  endtask

  task automatic test_out_of_band();
    logic [10:0] ys [2];
    ys[0] = 11'd399; ys[1] = 11'd480;
    tile_mask = 1'b1; tile_r = 8'hEE; tile_g = 8'hEE; tile_b = 8'hEE;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      px = 11'd100; py = ys[i]; pix_valid = 1'b1; {bg_r, bg_g, bg_b} = 24'h112233;
      @(posedge clk); #1;
      total++; if (tile_x !== 11'd16 || tile_y !== 11'd16) begin bad++; $display("FAIL oob_tile y=%0d got=(%0d,%0d) want=(16,16)", ys[i], tile_x, tile_y); end
      @(negedge clk) pix_valid = 1'b0;
      @(posedge clk); #1;
      total++; if ({out_r, out_g, out_b} !== 24'h112233 || out_valid !== 1'b1) begin bad++; $display("FAIL oob_out y=%0d got=%h v=%b want=112233 v=1", ys[i], {out_r, out_g, out_b}, out_valid); end
      $display("pixel (100,%0d): tile=(%0d,%0d) out=%h", ys[i], tile_x, tile_y, {out_r, out_g, out_b});
    end
  endtask

  task automatic test_mask();
    tile_mask = 1'b0;
    drive_pix(11'd20, 11'd450, 24'hAABBCC);
    @(posedge clk); #1;
    total++; if ({out_r, out_g, out_b} !== 24'hAABBCC) begin bad++; $display("FAIL mask0_out got=%h want=aabbcc", {out_r, out_g, out_b}); end
    $display("mask=0 in band: out=%h", {out_r, out_g, out_b});
    tile_mask = 1'b1;
    @(negedge clk);
    px = 11'd20; py = 11'd450; pix_valid = 1'b0; {bg_r, bg_g, bg_b} = 24'hAABBCC;
    @(posedge clk); @(posedge clk); #1;
    total++; if ({out_r, out_g, out_b} !== 24'h0 || out_valid !== 1'b0) begin bad++; $display("FAIL invalid_out got=%h v=%b want=000000 v=0", {out_r, out_g, out_b}, out_valid); end
    $display("pix_valid=0: out=%h valid=%b", {out_r, out_g, out_b}, out_valid);
  endtask

  task automatic test_restart();
    // scroll is 2 and STOPPED: enter RUNNING, then advance to 6
    run = 1'b1;
    do_tick(); // enter RUNNING, 2
    do_tick(); // 4
    do_tick(); // 6
    total++; if (scroll_pos !== 4'd6) begin bad++; $display("FAIL restart_setup got=%0d want=6", scroll_pos); end
    @(negedge clk) restart = 1'b1;
    @(negedge clk) restart = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (scroll_pos !== 4'd6) begin bad++; $display("FAIL restart_hold got=%0d want=6", scroll_pos); end
    do_tick();
    total++; if (scroll_pos !== 4'd0) begin bad++; $display("FAIL restart_zero got=%0d want=0", scroll_pos); end
    do_tick();
    total++; if (scroll_pos !== 4'd2) begin bad++; $display("FAIL restart_resume got=%0d want=2", scroll_pos); end
    $display("restart sequence: scroll=%0d", scroll_pos);
  endtask

  task automatic test_restart_same_tick();
    do_tick();
    total++; if (scroll_pos !== 4'd4) begin bad++; $display("FAIL rt_pre got=%0d want=4", scroll_pos); end
    @(negedge clk) begin frame_tick = 1'b1; restart = 1'b1; end
    @(negedge clk) begin frame_tick = 1'b0; restart = 1'b0; end
    total++; if (scroll_pos !== 4'd0) begin bad++; $display("FAIL rt_same got=%0d want=0", scroll_pos); end
    do_tick();
    total++; if (scroll_pos !== 4'd2) begin bad++; $display("FAIL rt_after got=%0d want=2", scroll_pos); end
    $display("restart+tick: scroll=%0d", scroll_pos);
  endtask

  task automatic test_back_to_back();
    // scroll is 2; four consecutive in-band pixels, transparent tile
    tile_mask = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 4) begin
        px = 11'(k); py = 11'd400; pix_valid = 1'b1;
        {bg_r, bg_g, bg_b} = {16'h0, 8'(k * 16 + 1)};
      end else begin
        pix_valid = 1'b0; {bg_r, bg_g, bg_b} = 24'h0;
      end
      @(posedge clk); #1;
      if (k < 4) begin
        total++; if (tile_x !== 11'(k + 2)) begin bad++; $display("FAIL b2b_tile_x k=%0d got=%0d want=%0d", k, tile_x, k + 2); end
      end
      if (k >= 1 && k <= 4) begin
        total++; if (out_b !== 8'((k - 1) * 16 + 1) || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_out k=%0d got=%h v=%b want=%h v=1", k, out_b, out_valid, 8'((k - 1) * 16 + 1)); end
      end
      $display("b2b cycle %0d: tile_x=%0d out_b=%h valid=%b", k, tile_x, out_b, out_valid);
    end
  endtask

  task automatic test_async_reset();
    tile_mask = 1'b1; tile_r = 8'h33; tile_g = 8'h44; tile_b = 8'h55;
    @(negedge clk);
    px = 11'd7; py = 11'd420; pix_valid = 1'b1; {bg_r, bg_g, bg_b} = 24'h010101;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_out_valid got=%b want=0", out_valid); end
    total++; if (scroll_pos !== 4'd0) begin bad++; $display("FAIL arst_scroll got=%0d want=0", scroll_pos); end
    total++; if (tile_x !== 11'd16) begin bad++; $display("FAIL arst_tile_x got=%0d want=16", tile_x); end
    $display("async reset: out_valid=%b scroll=%0d tile_x=%0d", out_valid, scroll_pos, tile_x);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL refill_early got=%b want=0", out_valid); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || out_r !== 8'h33) begin bad++; $display("FAIL refill got v=%b r=%h want v=1 r=33", out_valid, out_r); end
    $display("refill: out_valid=%b out_r=%h", out_valid, out_r);
    @(negedge clk) pix_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; px = '0; py = '0; pix_valid = 1'b0;
    bg_r = '0; bg_g = '0; bg_b = '0;
    frame_tick = 1'b0; run = 1'b0; restart = 1'b0;
    tile_r = '0; tile_g = '0; tile_b = '0; tile_mask = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    @(negedge clk) rst = 1'b0;
    test_stopped();
    test_scroll();
    test_out_of_band();
    test_mask();
    test_restart();
    test_restart_same_tick();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
